fwd_sequencer: RTL and testbench

//  Drives the forwarder side of fwd_adapter: accepts a ready packet from the P3

---
 rtl/fwd_sequencer.sv | 143 ++++++++++++++
 tb/tb_fwd_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_sequencer.sv
// Forwarder-side packet sequencer: claims a ready packet, streams its words out of packet
// memory as AXI-Stream with tkeep/tlast, and pulses fwd_done when the packet is emitted.
module fwd_sequencer #(
  parameter int unsigned PACKMEM_ADDR_WIDTH = 8,
  parameter int unsigned PACKMEM_DATA_WIDTH = 64,
  parameter int unsigned PLEN_WIDTH         = 32,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_rdy_for_fwd,
  input  logic [PLEN_WIDTH-1:0]           i_fwd_bytes,
  output logic                            o_rdy_for_fwd_ack,
  output logic [PACKMEM_ADDR_WIDTH-1:0]   o_fwd_addr,
  output logic                            o_fwd_rd_en,
  input  logic [PACKMEM_DATA_WIDTH-1:0]   i_fwd_rd_data,
  input  logic                            i_fwd_rd_data_vld,
  output logic                            o_fwd_done,
  output logic [PACKMEM_DATA_WIDTH-1:0]   o_m_axis_tdata,
  output logic [PACKMEM_DATA_WIDTH/8-1:0] o_m_axis_tkeep,
  output logic                            o_m_axis_tlast,
  output logic                            o_m_axis_tvalid,
  input  logic                            i_m_axis_tready
);

  localparam int unsigned AW  = PACKMEM_ADDR_WIDTH;
  localparam int unsigned DW  = PACKMEM_DATA_WIDTH;
  localparam int unsigned BPW = DW / 8;
  localparam int unsigned BW  = $clog2(BPW);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [AW:0]           r_nwords;
  logic [BW-1:0]         r_rem;
  logic [AW:0]           r_issued;
  logic [AW:0]           r_beats;
  logic [CW-1:0]         r_outst;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DW-1:0]         r_mem [FIFO_DEPTH];

  logic [PLEN_WIDTH-1:0] w_ceil;
  logic [BW-1:0]         w_rem;
  logic                  w_trunc;
  logic [AW:0]           w_nwords;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_tvalid;
  logic                  w_last;
  logic [BPW-1:0]        w_keep_last;

  // ceil(len/BPW) exceeds 2^AW exactly when len exceeds 2^AW*BPW, so one compare clamps.
  assign w_rem    = i_fwd_bytes[BW-1:0];
  assign w_ceil   = (i_fwd_bytes >> BW) + PLEN_WIDTH'(w_rem != '0);
  assign w_trunc  = w_ceil > PLEN_WIDTH'(2 ** AW);
  assign w_nwords = w_trunc ? {1'b1, {AW{1'b0}}} : w_ceil[AW:0];

  assign w_push   = (r_state == StRead) && i_fwd_rd_data_vld;
  assign w_tvalid = r_count != '0;
  assign w_pop    = w_tvalid && i_m_axis_tready;
  assign w_last   = w_tvalid && (r_beats == r_nwords - (AW + 1)'(1));

  assign w_keep_last = (r_rem == '0) ? {BPW{1'b1}} : ~({BPW{1'b1}} << r_rem);

  // Reads in flight plus buffered words never exceed the FIFO, so a push always fits.
  assign o_fwd_rd_en = (r_state == StRead) && (r_issued < r_nwords) &&
                       (({1'b0, r_outst} + {1'b0, r_count}) < (CW + 1)'(FIFO_DEPTH));
  assign o_fwd_addr  = r_issued[AW-1:0];

  assign o_m_axis_tvalid = w_tvalid;
  assign o_m_axis_tdata  = w_tvalid ? r_mem[r_rd_ptr] : '0;
  assign o_m_axis_tlast  = w_last;
  assign o_m_axis_tkeep  = !w_tvalid ? '0 : (w_last ? w_keep_last : {BPW{1'b1}});

  always_comb begin
    w_state_nxt       = r_state;
    o_rdy_for_fwd_ack = 1'b0;
    o_fwd_done        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_rdy_for_fwd) begin
          o_rdy_for_fwd_ack = 1'b1;
          w_state_nxt       = (w_nwords == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (w_pop && w_last) w_state_nxt = StDone;
      end
      StDone: begin
        o_fwd_done  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_nwords <= '0;
      r_rem    <= '0;
      r_issued <= '0;
      r_beats  <= '0;
      r_outst  <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_rdy_for_fwd_ack) begin
        r_nwords <= w_nwords;
        r_rem    <= w_trunc ? '0 : w_rem;
        r_issued <= '0;
        r_beats  <= '0;
      end else begin
        if (o_fwd_rd_en) r_issued <= r_issued + 1'b1;
        if (w_pop)       r_beats  <= r_beats + 1'b1;
      end
      unique case ({o_fwd_rd_en, w_push})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_fwd_rd_data;
  end

endmodule

// File: tb/tb_fwd_sequencer.sv
// Directed bench for fwd_sequencer: packet table plus reset-abort and stray-data sequences,
// with a variable-latency packet memory model.
module tb_fwd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [31:0] bytes_in = '0;
  logic        ack;
  logic [7:0]  addr;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        rd_vld;
  logic        done;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int mem_lat = 1;

  fwd_sequencer #(
    .PACKMEM_ADDR_WIDTH(8),
    .PACKMEM_DATA_WIDTH(64),
    .PLEN_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rdy_for_fwd    (rdy),
    .i_fwd_bytes      (bytes_in),
    .o_rdy_for_fwd_ack(ack),
    .o_fwd_addr       (addr),
    .o_fwd_rd_en      (rd_en),
    .i_fwd_rd_data    (rd_data),
    .i_fwd_rd_data_vld(rd_vld),
    .o_fwd_done       (done),
    .o_m_axis_tdata   (tdata),
    .o_m_axis_tkeep   (tkeep),
    .o_m_axis_tlast   (tlast),
    .o_m_axis_tvalid  (tvalid),
    .i_m_axis_tready  (tready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [7:0] a);
    return {8{a}} ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Memory model: a request seen at one falling edge returns mem_lat falling edges later.
  logic       st_v [4];
  logic [7:0] st_a [4];
  initial begin
    rd_vld  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      st_v[i] = 1'b0;
      st_a[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 3; i > 0; i--) begin
        st_v[i] = st_v[i-1];
        st_a[i] = st_a[i-1];
      end
      st_v[0] = rd_en;
      st_a[0] = addr;
      rd_vld  = st_v[mem_lat];
      rd_data = st_v[mem_lat] ? mem_word(st_a[mem_lat]) : '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, {63'd0, ack}, 64'd0);
    chk({tag, "_rd_en"}, {63'd0, rd_en}, 64'd0);
    chk({tag, "_addr"}, {56'd0, addr}, 64'd0);
    chk({tag, "_tvalid"}, {63'd0, tvalid}, 64'd0);
    chk({tag, "_tdata"}, tdata, 64'd0);
    chk({tag, "_tkeep"}, {56'd0, tkeep}, 64'd0);
    chk({tag, "_tlast"}, {63'd0, tlast}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  // mode 0: tready always 1; mode 1: tready low for 20 cycles; mode 2: random tready.
  task automatic run_pkt(input int nbytes, input int lat, input int mode, input int exp_beats,
                         input logic [7:0] exp_keep, input int abort_at);
    int beats = 0;
    int reads = 0;
    int last_cyc = -1;
    bit got_done = 1'b0;
    bit hold = 1'b0;
    logic [63:0] hd = '0;
    logic [7:0]  hk = '0;
    logic        hl = 1'b0;
    mem_lat = lat;
    @(negedge clk);
    rdy      = 1'b1;
    bytes_in = nbytes;
    #1;
    chk("ack", {63'd0, ack}, 64'd1);
    @(negedge clk);
    rdy      = 1'b0;
    bytes_in = '0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      tready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc >= 20) : 1'($urandom_range(0, 1));
      #1;
      if (ack) chk("ack_repeat", {63'd0, ack}, 64'd0);
      if (rd_en) begin
        chk("rd_addr", {56'd0, addr}, 64'(reads % 256));
        reads++;
        chk("credit", {63'd0, 1'((reads - beats) <= 4)}, 64'd1);
      end
      if (mode == 1 && cyc == 19) chk("stall_reads", 64'(reads), 64'd4);
      if (hold) begin
        chk("hold_valid", {63'd0, tvalid}, 64'd1);
        chk("hold_data", tdata, hd);
        chk("hold_keep", {56'd0, tkeep}, {56'd0, hk});
        chk("hold_last", {63'd0, tlast}, {63'd0, hl});
      end
      if (tvalid && tready) begin
        chk("tdata", tdata, mem_word(8'(beats)));
        chk("tkeep", {56'd0, tkeep},
            {56'd0, (beats == exp_beats - 1) ? exp_keep : 8'hFF});
        chk("tlast", {63'd0, tlast}, {63'd0, 1'(beats == exp_beats - 1)});
        beats++;
        if (beats == exp_beats) last_cyc = cyc;
        if (beats == abort_at) begin
          rst = 1'b1;
          #1;
          chk_idle_outputs("abort");
          return;
        end
      end
      hold = tvalid && !tready;
      hd   = tdata;
      hk   = tkeep;
      hl   = tlast;
      if (done) begin
        got_done = 1'b1;
        chk("done_timing", 64'(cyc), 64'(last_cyc + 1));
      end
    end
    chk("done_seen", {63'd0, got_done}, 64'd1);
    chk("beats", 64'(beats), 64'(exp_beats));
    chk("reads", 64'(reads), 64'(exp_beats));
    @(negedge clk);
    #1;
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("post_tvalid", {63'd0, tvalid}, 64'd0);
    tready = 1'b0;
  endtask

  typedef struct {
    int         nbytes;
    int         lat;
    int         mode;
    int         beats;
    logic [7:0] keep;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{nbytes: 64,   lat: 1, mode: 0, beats: 8,   keep: 8'hFF};
    vecs[1] = '{nbytes: 13,   lat: 1, mode: 0, beats: 2,   keep: 8'h1F};
    vecs[2] = '{nbytes: 0,    lat: 1, mode: 0, beats: 0,   keep: 8'hFF};
    vecs[3] = '{nbytes: 128,  lat: 3, mode: 1, beats: 16,  keep: 8'hFF};
    vecs[4] = '{nbytes: 5000, lat: 1, mode: 0, beats: 256, keep: 8'hFF};
    vecs[5] = '{nbytes: 2048, lat: 2, mode: 2, beats: 256, keep: 8'hFF};
    vecs[6] = '{nbytes: 2049, lat: 1, mode: 0, beats: 256, keep: 8'hFF};
    vecs[7] = '{nbytes: 2041, lat: 2, mode: 2, beats: 256, keep: 8'h01};
    vecs[8] = '{nbytes: 1,    lat: 2, mode: 2, beats: 1,   keep: 8'h01};
    vecs[9] = '{nbytes: 7,    lat: 3, mode: 2, beats: 1,   keep: 8'h7F};

    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      run_pkt(vecs[v].nbytes, vecs[v].lat, vecs[v].mode, vecs[v].beats, vecs[v].keep, 0);
      repeat (4) @(negedge clk);
    end

    // Abort on reset at beat 3 with long latency so returns land after reset is released.
    run_pkt(64, 3, 0, 8, 8'hFF, 3);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("stray_ignored", {63'd0, tvalid}, 64'd0);
    chk("stray_done", {63'd0, done}, 64'd0);
    run_pkt(24, 1, 0, 3, 8'hFF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
